// File: rtl/speed_decoder_if.sv
// Tick-stream in / recovered-rate out bundle for speed_decoder.
// Latency: n/a (wires only). Backpressure: none; the tick stream cannot be stalled.
// Ports: enable, tick_in (to decoder); period_out, rate_out, rate_valid,
//        locked, change_pulse, stall (from decoder).
interface speed_decoder_if;
   logic       enable;
   logic       tick_in;
   logic [5:0] period_out;
   logic [2:0] rate_out;
   logic       rate_valid;
   logic       locked;
   logic       change_pulse;
   logic       stall;

   // master drives the tick stream and observes the decode
   modport master (
      output enable, tick_in,
      input  period_out, rate_out, rate_valid, locked, change_pulse, stall
   );

   // slave is the decoder itself
   modport slave (
      input  enable, tick_in,
      output period_out, rate_out, rate_valid, locked, change_pulse, stall
   );
endinterface

// File: rtl/speed_decoder.sv
// Measures tick-to-tick spacing, locks once CONFIRM equal periods are seen, decodes the rate code.
// Latency: all outputs registered on the edge that samples the tick, visible the next cycle.
// Backpressure: none; every sampled-high tick_in cycle is consumed as one tick event.
// Ports: clk, reset (async, active-high), bus (speed_decoder_if.slave):
//        enable, tick_in in; period_out, rate_out, rate_valid, locked, change_pulse, stall out.
module speed_decoder #(
   parameter int MAX_PERIOD = 63,   // 8..63, cycles without a tick before stall
   parameter int CONFIRM    = 2     // 1..7, equal periods needed for lock
) (
   input  logic              clk,
   input  logic              reset,
   speed_decoder_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, STALL} state_t;

   localparam logic [5:0] MAX_CNT = 6'(MAX_PERIOD);
   localparam logic [2:0] CONF    = 3'(CONFIRM);

   state_t     state;
   logic [5:0] cnt;
   logic [5:0] prev_period;
   logic [2:0] match_cnt;

   logic [5:0] period_out;
   logic [2:0] rate_out;
   logic       rate_valid;
   logic       locked;
   logic       change_pulse;
   logic       stall;

   // next-state of the lock/decode path, used only when a tick lands in MEASURE
   logic       legal;
   logic [2:0] dec_rate;
   logic [2:0] match_nxt;
   logic       lock_nxt;
   logic       valid_nxt;
   logic [2:0] rate_nxt;

   always_comb begin
      legal    = 1'b1;
      dec_rate = 3'd0;
      // rates 4..6 all produce period 2; report the canonical 4
      case (cnt)
         6'd7:    dec_rate = 3'd1;
         6'd4:    dec_rate = 3'd2;
         6'd3:    dec_rate = 3'd3;
         6'd2:    dec_rate = 3'd4;
         default: legal    = 1'b0;
      endcase

      // prev_period is 0 after ARM/enable-clear, so the first period never matches
      if (cnt == prev_period)
         match_nxt = (match_cnt >= CONF) ? CONF : match_cnt + 3'd1;
      else
         match_nxt = 3'd1;

      lock_nxt  = (match_nxt == CONF);
      valid_nxt = lock_nxt & legal;
      rate_nxt  = valid_nxt ? dec_rate : 3'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= 6'd0;
         prev_period  <= 6'd0;
         match_cnt    <= 3'd0;
         period_out   <= 6'd0;
         rate_out     <= 3'd0;
         rate_valid   <= 1'b0;
         locked       <= 1'b0;
         change_pulse <= 1'b0;
         stall        <= 1'b0;
      end else if (!bus.enable) begin
         // synchronous clear; a tick in this cycle is deliberately dropped
         state        <= IDLE;
         cnt          <= 6'd0;
         prev_period  <= 6'd0;
         match_cnt    <= 3'd0;
         period_out   <= 6'd0;
         rate_out     <= 3'd0;
         rate_valid   <= 1'b0;
         locked       <= 1'b0;
         change_pulse <= 1'b0;
         stall        <= 1'b0;
      end else begin
         change_pulse <= 1'b0;
         case (state)
            IDLE: state <= ARM;

            ARM: begin
               // first tick only opens the interval, no period recorded
               if (bus.tick_in) begin
                  cnt   <= 6'd1;
                  state <= MEASURE;
               end
            end

            MEASURE: begin
               // a tick on the same cycle cnt hits MAX_CNT wins over the timeout
               if (bus.tick_in) begin
                  period_out   <= cnt;
                  prev_period  <= cnt;
                  cnt          <= 6'd1;
                  match_cnt    <= match_nxt;
                  locked       <= lock_nxt;
                  rate_valid   <= valid_nxt;
                  rate_out     <= rate_nxt;
                  change_pulse <= valid_nxt & ((rate_nxt != rate_out) | ~rate_valid);
               end else if (cnt == MAX_CNT) begin
                  // cnt holds at MAX_CNT; period_out keeps the last good period
                  state      <= STALL;
                  stall      <= 1'b1;
                  locked     <= 1'b0;
                  rate_valid <= 1'b0;
                  rate_out   <= 3'd0;
                  match_cnt  <= 3'd0;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end

            STALL: begin
               // restart like ARM: match_cnt stays 0 until a period is measured
               if (bus.tick_in) begin
                  stall <= 1'b0;
                  cnt   <= 6'd1;
                  state <= MEASURE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.period_out   = period_out;
   assign bus.rate_out     = rate_out;
   assign bus.rate_valid   = rate_valid;
   assign bus.locked       = locked;
   assign bus.change_pulse = change_pulse;
   assign bus.stall        = stall;

endmodule
